// File: rtl/garage_lot_controller.sv
// rtl/garage_lot_controller.sv - two-gate garage lot controller with occupancy count and 7-seg display
module garage_lot_controller #(
    parameter int CAPACITY     = 40,
    parameter int CNT_W        = 7,
    parameter int GATE_HOLD    = 4,
    parameter int OPEN_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             car_enter,
    input  logic             car_out,
    input  logic             entry_passed,
    input  logic             exit_passed,
    output logic [CNT_W-1:0] car_count,
    output logic             garage_full,
    output logic             garage_empty,
    output logic             entry_gate_open,
    output logic             exit_gate_open,
    output logic             entry_reject,
    output logic [6:0]       leds1,
    output logic [6:0]       leds2,
    output logic [1:0]       cur_st,
    output logic [1:0]       exit_st
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OPEN = 2'b01,
        ST_HOLD = 2'b10,
        ST_BAD  = 2'b11
    } gate_st_t;

    localparam int TMAX  = (OPEN_TIMEOUT > GATE_HOLD) ? OPEN_TIMEOUT : GATE_HOLD;
    localparam int TMR_W = $clog2(TMAX + 1);
    localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(OPEN_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(GATE_HOLD - 1);
    localparam logic [CNT_W-1:0] CAP       = CNT_W'(CAPACITY);

    logic prev_enter, prev_out, prev_epass, prev_xpass;
    logic enter_edge, out_edge, epass_edge, xpass_edge;

    gate_st_t         en_st, en_st_nx, ex_st, ex_st_nx;
    logic [TMR_W-1:0] en_tmr, en_tmr_nx, ex_tmr, ex_tmr_nx;
    logic             en_inc, ex_dec, reject_nx;
    logic             inc_ok, dec_ok;
    logic [3:0]       units, tens;

    assign enter_edge = car_enter & ~prev_enter;
    assign out_edge   = car_out & ~prev_out;
    assign epass_edge = entry_passed & ~prev_epass;
    assign xpass_edge = exit_passed & ~prev_xpass;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_enter   <= 1'b0;
            prev_out     <= 1'b0;
            prev_epass   <= 1'b0;
            prev_xpass   <= 1'b0;
            en_st        <= ST_IDLE;
            ex_st        <= ST_IDLE;
            en_tmr       <= '0;
            ex_tmr       <= '0;
            entry_reject <= 1'b0;
        end else begin
            prev_enter   <= car_enter;
            prev_out     <= car_out;
            prev_epass   <= entry_passed;
            prev_xpass   <= exit_passed;
            en_st        <= en_st_nx;
            ex_st        <= ex_st_nx;
            en_tmr       <= en_tmr_nx;
            ex_tmr       <= ex_tmr_nx;
            entry_reject <= reject_nx;
        end
    end

    // A pass on the final open cycle still counts: pass wins over timeout.
    always_comb begin
        en_st_nx  = en_st;
        en_tmr_nx = en_tmr + 1'b1;
        en_inc    = 1'b0;
        reject_nx = 1'b0;
        case (en_st)
            ST_IDLE: begin
                en_tmr_nx = '0;
                if (enter_edge) begin
                    if (car_count < CAP) en_st_nx = ST_OPEN;
                    else                 reject_nx = 1'b1;
                end
            end
            ST_OPEN: begin
                if (epass_edge) begin
                    en_st_nx  = ST_HOLD;
                    en_tmr_nx = '0;
                    en_inc    = 1'b1;
                end else if (en_tmr == TO_LAST) begin
                    en_st_nx  = ST_IDLE;
                    en_tmr_nx = '0;
                end
            end
            ST_HOLD: begin
                if (en_tmr == HOLD_LAST) begin
                    en_st_nx  = ST_IDLE;
                    en_tmr_nx = '0;
                end
            end
            default: begin
                en_st_nx  = ST_IDLE;
                en_tmr_nx = '0;
            end
        endcase
    end

    // Requests on an empty lot are dropped silently; there is no exit reject.
    always_comb begin
        ex_st_nx  = ex_st;
        ex_tmr_nx = ex_tmr + 1'b1;
        ex_dec    = 1'b0;
        case (ex_st)
            ST_IDLE: begin
                ex_tmr_nx = '0;
                if (out_edge && car_count != '0) ex_st_nx = ST_OPEN;
            end
            ST_OPEN: begin
                if (xpass_edge) begin
                    ex_st_nx  = ST_HOLD;
                    ex_tmr_nx = '0;
                    ex_dec    = 1'b1;
                end else if (ex_tmr == TO_LAST) begin
                    ex_st_nx  = ST_IDLE;
                    ex_tmr_nx = '0;
                end
            end
            ST_HOLD: begin
                if (ex_tmr == HOLD_LAST) begin
                    ex_st_nx  = ST_IDLE;
                    ex_tmr_nx = '0;
                end
            end
            default: begin
                ex_st_nx  = ST_IDLE;
                ex_tmr_nx = '0;
            end
        endcase
    end

    assign inc_ok = en_inc && (car_count < CAP);
    assign dec_ok = ex_dec && (car_count != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            car_count <= '0;
        end else begin
            case ({inc_ok, dec_ok})
                2'b10:   car_count <= car_count + 1'b1;
                2'b01:   car_count <= car_count - 1'b1;
                default: car_count <= car_count;
            endcase
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    assign units = 4'(32'(car_count) % 32'd10);
    assign tens  = 4'(32'(car_count) / 32'd10);

    assign leds1           = seg7(units);
    assign leds2           = seg7(tens);
    assign garage_full     = (car_count == CAP);
    assign garage_empty    = (car_count == '0);
    assign entry_gate_open = (en_st == ST_OPEN) || (en_st == ST_HOLD);
    assign exit_gate_open  = (ex_st == ST_OPEN) || (ex_st == ST_HOLD);
    assign cur_st          = en_st;
    assign exit_st         = ex_st;

endmodule

// File: tb/tb_garage_lot_controller.sv
// tb/tb_garage_lot_controller.sv - randomized + directed bench with timeline reference model
module tb_garage_lot_controller;

    localparam int CAP = 40;
    localparam int CW  = 7;
    localparam int GH  = 4;
    localparam int TO  = 16;
    localparam logic [6:0] SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          car_enter = 1'b0, car_out = 1'b0;
    logic          entry_passed = 1'b0, exit_passed = 1'b0;
    logic [CW-1:0] car_count;
    logic          garage_full, garage_empty, entry_gate_open, exit_gate_open, entry_reject;
    logic [6:0]    leds1, leds2;
    logic [1:0]    cur_st, exit_st;

    int n_tests = 0;
    int n_fail  = 0;

    garage_lot_controller #(
        .CAPACITY(CAP), .CNT_W(CW), .GATE_HOLD(GH), .OPEN_TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .car_enter(car_enter), .car_out(car_out),
        .entry_passed(entry_passed), .exit_passed(exit_passed),
        .car_count(car_count), .garage_full(garage_full), .garage_empty(garage_empty),
        .entry_gate_open(entry_gate_open), .exit_gate_open(exit_gate_open),
        .entry_reject(entry_reject), .leds1(leds1), .leds2(leds2),
        .cur_st(cur_st), .exit_st(exit_st)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Timeline model: each gate is closed / open-waiting / passed, with an absolute close time.
    typedef struct {
        int cnt;
        int t;
        int en_ph;
        int ex_ph;
        int en_close;
        int ex_close;
        bit rej;
        bit p_ce, p_co, p_ep, p_xp;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t step(mdl_t s, bit ce, bit co, bit ep, bit xp);
        mdl_t n   = s;
        bit   er  = ce & ~s.p_ce;
        bit   xr  = co & ~s.p_co;
        bit   epe = ep & ~s.p_ep;
        bit   xpe = xp & ~s.p_xp;
        int   inc = 0;
        int   dec = 0;
        n.t   = s.t + 1;
        n.rej = 1'b0;
        if (s.en_ph == 0) begin
            if (er) begin
                if (s.cnt < CAP) begin n.en_ph = 1; n.en_close = n.t + TO; end
                else n.rej = 1'b1;
            end
        end else if (s.en_ph == 1 && epe) begin
            n.en_ph = 2; n.en_close = n.t + GH; inc = 1;
        end else if (n.t >= s.en_close) begin
            n.en_ph = 0;
        end
        if (s.ex_ph == 0) begin
            if (xr && s.cnt > 0) begin n.ex_ph = 1; n.ex_close = n.t + TO; end
        end else if (s.ex_ph == 1 && xpe) begin
            n.ex_ph = 2; n.ex_close = n.t + GH; dec = 1;
        end else if (n.t >= s.ex_close) begin
            n.ex_ph = 0;
        end
        n.cnt  = s.cnt + inc - dec;
        n.p_ce = ce; n.p_co = co; n.p_ep = ep; n.p_xp = xp;
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m <= '{default: 0};
        else        m <= step(m, car_enter, car_out, entry_passed, exit_passed);
    end

    always @(negedge clk) begin
        if (reset) begin
            check("car_count", int'(car_count), m.cnt);
            check("garage_full", int'(garage_full), int'(m.cnt == CAP));
            check("garage_empty", int'(garage_empty), int'(m.cnt == 0));
            check("entry_gate_open", int'(entry_gate_open), int'(m.en_ph != 0));
            check("exit_gate_open", int'(exit_gate_open), int'(m.ex_ph != 0));
            check("entry_reject", int'(entry_reject), int'(m.rej));
            check("cur_st", int'(cur_st), m.en_ph);
            check("exit_st", int'(exit_st), m.ex_ph);
            check("leds1", int'(leds1), int'(SEG[m.cnt % 10]));
            check("leds2", int'(leds2), int'(SEG[m.cnt / 10]));
        end
    end

    task automatic reset_values(input string tag);
        check({tag, "_count"}, int'(car_count), 0);
        check({tag, "_empty"}, int'(garage_empty), 1);
        check({tag, "_full"}, int'(garage_full), 0);
        check({tag, "_gates"}, int'({entry_gate_open, exit_gate_open}), 0);
        check({tag, "_reject"}, int'(entry_reject), 0);
        check({tag, "_states"}, int'({cur_st, exit_st}), 0);
        check({tag, "_leds1"}, int'(leds1), 'h3F);
        check({tag, "_leds2"}, int'(leds2), 'h3F);
    endtask

    task automatic enter_car();
        @(negedge clk) car_enter = 1'b1;
        @(negedge clk) check("entry_open_latency", int'(entry_gate_open), 1);
        car_enter = 1'b0; entry_passed = 1'b1;
        @(negedge clk) entry_passed = 1'b0;
        check("entry_open_after_pass", int'(entry_gate_open), 1);
        repeat (GH - 1) @(negedge clk);
        check("entry_open_hold_end", int'(entry_gate_open), 1);
        @(negedge clk) check("entry_closed_after_hold", int'(entry_gate_open), 0);
    endtask

    task automatic exit_car();
        @(negedge clk) car_out = 1'b1;
        @(negedge clk) check("exit_open_latency", int'(exit_gate_open), 1);
        car_out = 1'b0; exit_passed = 1'b1;
        @(negedge clk) exit_passed = 1'b0;
        repeat (GH - 1) @(negedge clk);
        check("exit_open_hold_end", int'(exit_gate_open), 1);
        @(negedge clk) check("exit_closed_after_hold", int'(exit_gate_open), 0);
    endtask

    initial begin
        int open_cycles, opens;
        bit prev_open;

        repeat (3) @(negedge clk);
        reset_values("por");
        reset = 1'b1;

        repeat (3) enter_car();
        check("three_cars_count", int'(car_count), 3);
        check("three_cars_leds1", int'(leds1), 'h4F);
        check("three_cars_leds2", int'(leds2), 'h3F);
        check("model_three_cars", m.cnt, 3);

        repeat (CAP - 3) enter_car();
        check("fill_full", int'(garage_full), 1);
        check("fill_leds2", int'(leds2), 'h66);
        check("fill_leds1", int'(leds1), 'h3F);

        @(negedge clk) car_enter = 1'b1;
        @(negedge clk) check("reject_pulse", int'(entry_reject), 1);
        check("reject_gate_closed", int'(entry_gate_open), 0);
        car_enter = 1'b0;
        @(negedge clk) check("reject_single", int'(entry_reject), 0);
        check("reject_count", int'(car_count), CAP);

        repeat (CAP - 10) exit_car();
        check("down_to_ten", int'(car_count), 10);

        @(negedge clk) begin car_enter = 1'b1; car_out = 1'b1; end
        @(negedge clk) begin
            car_enter = 1'b0; car_out = 1'b0;
            entry_passed = 1'b1; exit_passed = 1'b1;
        end
        @(negedge clk) begin entry_passed = 1'b0; exit_passed = 1'b0; end
        check("simultaneous_count", int'(car_count), 10);
        check("model_simultaneous", m.cnt, 10);
        repeat (GH + 2) @(negedge clk);

        repeat (10) exit_car();
        @(negedge clk) car_out = 1'b1;
        @(negedge clk) check("empty_exit_closed", int'(exit_gate_open), 0);
        check("empty_exit_count", int'(car_count), 0);
        check("empty_exit_no_pulse", int'(entry_reject), 0);
        car_out = 1'b0;

        open_cycles = 0; opens = 0; prev_open = 1'b0;
        @(negedge clk) car_enter = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (entry_gate_open) open_cycles++;
            if (entry_gate_open && !prev_open) opens++;
            prev_open = entry_gate_open;
        end
        car_enter = 1'b0;
        check("timeout_open_cycles", open_cycles, TO);
        check("timeout_single_open", opens, 1);
        check("timeout_count", int'(car_count), 0);

        repeat (4) enter_car();
        @(negedge clk) car_enter = 1'b1;
        @(negedge clk) begin car_enter = 1'b0; entry_passed = 1'b1; end
        @(negedge clk) entry_passed = 1'b0;
        check("pre_reset_count", int'(car_count), 5);
        check("pre_reset_hold", int'(cur_st), 2);
        #2 reset = 1'b0;
        #1 reset_values("mid_hold_reset");
        @(negedge clk) reset = 1'b1;

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (i == 1500) begin
                #2 reset = 1'b0;
                @(negedge clk) reset = 1'b1;
            end
            if (i < 2000) begin
                car_enter    = ($urandom_range(0, 2) == 0);
                entry_passed = ($urandom_range(0, 2) == 0);
                car_out      = ($urandom_range(0, 6) == 0);
                exit_passed  = ($urandom_range(0, 4) == 0);
            end else begin
                car_enter    = ($urandom_range(0, 6) == 0);
                entry_passed = ($urandom_range(0, 4) == 0);
                car_out      = ($urandom_range(0, 2) == 0);
                exit_passed  = ($urandom_range(0, 2) == 0);
            end
        end
        car_enter = 1'b0; car_out = 1'b0; entry_passed = 1'b0; exit_passed = 1'b0;
        repeat (TO + 4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/garage_lot_controller.md
# garage_lot_controller

Parametrised successor to the single-gate garage counter: one entry gate and one exit gate, each with its own gate FSM, occupancy counter bounded by a configurable capacity, full/empty flags and a two-digit seven-segment occupancy display. Cars are counted on the gate pass sensor, not on the request, so aborted entries do not corrupt the count. Sits between the lot sensors and the gate actuators and display of the garage top level.

## Interface
- CAPACITY, 40, lot size; legal 1..99.
- CNT_W, 7, counter width; 2^CNT_W > CAPACITY required.
- GATE_HOLD, 4, cycles a gate stays open after a pass; legal ≥1.
- OPEN_TIMEOUT, 16, cycles an open gate waits for a pass before closing uncounted; legal ≥1.

- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- car_enter  in  1  entry request sensor (level; rising edge = request).
- car_out  in  1  exit request sensor (level; rising edge = request).
- entry_passed  in  1  pass sensor beyond entry gate (rising edge = car through).
- exit_passed  in  1  pass sensor beyond exit gate (rising edge = car through).
- car_count  out  CNT_W  current occupancy, 0..CAPACITY.
- garage_full  out  1  car_count == CAPACITY.
- garage_empty  out  1  car_count == 0.
- entry_gate_open  out  1  entry FSM in OPEN or HOLD.
- exit_gate_open  out  1  exit FSM in OPEN or HOLD.
- entry_reject  out  1  one-cycle pulse: entry request refused because lot full.
- leds1  out  7  units digit of car_count, segments {g,f,e,d,c,b,a}, active-high.
- leds2  out  7  tens digit, same encoding.
- cur_st  out  2  entry FSM state.
- exit_st  out  2  exit FSM state.

## Operation
- All inputs synchronous to clk. Each sensor has a previous-value register; edge = in & ~prev. A held-high input yields exactly one edge.
- Gate FSM states (both gates): IDLE=00, OPEN=01, HOLD=10; 11 unused, recovers to IDLE.
- Entry FSM: IDLE + car_enter edge: if car_count < CAPACITY → OPEN, else entry_reject=1 for that cycle, stay IDLE. OPEN + entry_passed edge → HOLD, car_count +1. OPEN with no pass for OPEN_TIMEOUT cycles → IDLE, no count. HOLD lasts exactly GATE_HOLD cycles → IDLE.
- Exit FSM: identical, using car_out / exit_passed; IDLE + car_out edge with car_count == 0 is ignored (no open, no pulse); pass decrements.
- Request edges in OPEN/HOLD ignored (not queued). Pass edges in IDLE/HOLD ignored.
- Increment and decrement in the same cycle: car_count unchanged.
- car_count never exceeds CAPACITY nor goes below 0 (admission checks guarantee it; saturate regardless).
- Display: binary-to-BCD of registered car_count, combinational. Codes 0..9: 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex). Tens digit not blanked (shows 0).

## Timing
- Reset (async assert, sync release): car_count=0, garage_empty=1, garage_full=0, both gates closed, entry_reject=0, cur_st=exit_st=00, leds1=leds2=3F, edge registers cleared. Reset mid-operation aborts any open gate immediately without counting.
- Request sampled at edge N → FSM OPEN and gate_open=1 after edge N (1-cycle latency).
- Pass sampled at edge M → car_count, flags, leds updated after edge M; gate stays open through HOLD, closes after edge M+GATE_HOLD.
- entry_reject high exactly the cycle after the refused request edge.
- Timeout: gate_open high for exactly OPEN_TIMEOUT cycles when no pass.
- Flags and leds are combinational from car_count; no extra latency.

## Test plan
- Reset asserted mid-HOLD with count 5 → all outputs immediately at reset values, leds1=leds2=3F.
- Enter 3 cars (request then pass each) → car_count=3, leds1=4F, leds2=3F; gate open 1 cycle after request, closes GATE_HOLD cycles after each pass.
- CAPACITY=40, fill to 40 → garage_full=1, leds2=66, leds1=3F; further car_enter edge → entry_reject single pulse, entry gate stays closed, count 40.
- Empty lot, car_out edge → exit gate stays closed, count 0, no pulse.
- Count 10, entry pass and exit pass in same cycle → count stays 10.
- Entry request with no pass → gate open exactly 16 cycles, count unchanged; car_enter held high 50 cycles → only one open.
